// File: rtl/rx_fifo_read_arbiter.sv
// Round-robin arbiter sharing the PC receive FIFO read port
// between two burst consumers, with flush and starvation abort.
module rx_fifo_read_arbiter #(
  parameter int LEN_W          = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_flush,
  input  logic             i_fifo_empty,
  input  logic [31:0]      i_fifo_q,
  output logic             o_fifo_rdreq,
  input  logic [1:0]       i_req,
  input  logic [LEN_W-1:0] i_len0,
  input  logic [LEN_W-1:0] i_len1,
  input  logic [1:0]       i_stall,
  output logic [1:0]       o_grant,
  output logic [31:0]      o_data,
  output logic [1:0]       o_data_valid,
  output logic [1:0]       o_done,
  output logic             o_error,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_LAST,
    S_FLUSH
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic             owner;
  logic             ptr;
  logic             pick;
  logic [LEN_W-1:0] pick_len;
  logic [LEN_W-1:0] remaining;
  logic [15:0]      idle_cnt;

  assign o_data = i_fifo_q;
  assign o_busy = (state != S_IDLE);

  // Pointed requester wins if it asks, otherwise the other one.
  always_comb begin
    pick     = i_req[ptr] ? ptr : ~ptr;
    pick_len = pick ? i_len1 : i_len0;
  end

  // Read pacing: owner's stall and FIFO empty gate bursts;
  // flush drains whatever is left.
  always_comb begin
    o_fifo_rdreq = 1'b0;
    unique case (state)
      S_BURST: o_fifo_rdreq = !i_fifo_empty
                           && !i_stall[owner]
                           && (remaining != '0);
      S_FLUSH: o_fifo_rdreq = !i_fifo_empty;
      default: o_fifo_rdreq = 1'b0;
    endcase
  end

  // Arbitration FSM with registered grant/valid/done/error.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= S_IDLE;
      owner        <= 1'b0;
      ptr          <= 1'b0;
      remaining    <= '0;
      idle_cnt     <= '0;
      o_grant      <= '0;
      o_data_valid <= '0;
      o_done       <= '0;
      o_error      <= 1'b0;
    end else begin
      o_done       <= '0;
      o_error      <= 1'b0;
      o_data_valid <= '0;
      // A read issued in a flush cycle is dropped, not delivered.
      if (state == S_BURST && o_fifo_rdreq && !i_flush)
        o_data_valid <= {owner, !owner};
      if (i_flush) begin
        state   <= S_FLUSH;
        o_grant <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (|i_req) begin
              owner     <= pick;
              o_grant   <= {pick, !pick};
              remaining <= pick_len;
              idle_cnt  <= '0;
              state     <= S_BURST;
              if (pick_len == '0)
                o_done <= {pick, !pick};
            end
          end
          S_BURST: begin
            if (remaining == '0) begin
              state   <= S_IDLE;
              o_grant <= '0;
              ptr     <= ~owner;
            end else if (o_fifo_rdreq) begin
              remaining <= remaining - LEN_W'(1);
              idle_cnt  <= '0;
              if (remaining == LEN_W'(1)) begin
                state  <= S_LAST;
                o_done <= {owner, !owner};
              end
            end else if (idle_cnt == TMO_LAST) begin
              o_error <= 1'b1;
              state   <= S_IDLE;
              o_grant <= '0;
              ptr     <= ~owner;
            end else begin
              idle_cnt <= idle_cnt + 16'd1;
            end
          end
          S_LAST: begin
            state   <= S_IDLE;
            o_grant <= '0;
            ptr     <= ~owner;
          end
          S_FLUSH: begin
            if (i_fifo_empty)
              state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_fifo_read_arbiter.sv
// Bench for rx_fifo_read_arbiter: FIFO model, word scoreboard,
// invariant monitor, vector table and corner-case sequences.
module tb_rx_fifo_read_arbiter;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        fifo_empty;
  logic [31:0] fifo_q;
  logic        rdreq;
  logic [1:0]  req;
  logic [7:0]  len0;
  logic [7:0]  len1;
  logic [1:0]  stall;
  logic [1:0]  grant;
  logic [31:0] data;
  logic [1:0]  dvalid;
  logic [1:0]  done;
  logic        error;
  logic        busy;

  rx_fifo_read_arbiter #(
    .LEN_W(8),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .i_clock(clk),
    .i_reset_n(rst_n),
    .i_flush(flush),
    .i_fifo_empty(fifo_empty),
    .i_fifo_q(fifo_q),
    .o_fifo_rdreq(rdreq),
    .i_req(req),
    .i_len0(len0),
    .i_len1(len1),
    .i_stall(stall),
    .o_grant(grant),
    .o_data(data),
    .o_data_valid(dvalid),
    .o_done(done),
    .o_error(error),
    .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  // Normal-mode FIFO model: q valid the cycle after rdreq.
  logic [31:0] mem [0:63];
  int wp = 0;
  int rp = 0;
  int nxt = 1;
  assign fifo_empty = (wp == rp);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q <= '0;
      rp     <= wp;
    end else if (rdreq) begin
      fifo_q <= mem[rp & 63];
      rp     <= rp + 1;
    end
  end

  // Scoreboard entries: {owner, word}.
  logic [32:0] sb [$];

  task automatic push_fifo(input int n, input logic own,
                           input int nexp);
    for (int i = 0; i < n; i++) begin
      mem[wp & 63] = 32'(nxt);
      wp = wp + 1;
      if (i < nexp) sb.push_back({own, 32'(nxt)});
      nxt++;
    end
  endtask

  int cyc = 0;
  int vcount = 0;
  int donecnt = 0;
  int errcnt = 0;
  int last_rd = 0;
  int err_cyc = 0;
  logic [1:0] prev_grant = '0;

  // Monitor: after inputs settle, check invariants and words.
  always begin
    logic [32:0] e;
    @(negedge clk);
    #1;
    cyc++;
    if (rst_n) begin
      check("rd_when_empty", 64'(rdreq && fifo_empty), 64'd0);
      check("grant_onehot0", 64'($onehot0(grant)), 64'd1);
      check("valid_subset",
            64'(dvalid & ~(grant | prev_grant)), 64'd0);
      check("rd_when_stall",
            64'(rdreq && (|(grant & stall))), 64'd0);
      if (dvalid != 2'b00) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_word", 64'(dvalid), 64'd0);
        end else begin
          e = sb.pop_front();
          check("word_owner", 64'(dvalid),
                64'(e[32] ? 2'b10 : 2'b01));
          check("word_data", 64'(data), 64'(e[31:0]));
        end
        vcount++;
      end
      if (done != 2'b00) donecnt++;
      if (error) begin
        errcnt++;
        err_cyc = cyc;
      end
      if (rdreq) last_rd = cyc;
    end
    prev_grant = grant;
  end

  task automatic run_burst(input logic [1:0] r,
                           input logic [7:0] l0,
                           input logic [7:0] l1,
                           output logic [1:0] g,
                           output logic [1:0] d,
                           output int span);
    int gi;
    req  = r;
    len0 = l0;
    len1 = l1;
    g    = '0;
    d    = '0;
    gi   = 0;
    span = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (g == 2'b00 && grant != 2'b00) begin
        g   = grant;
        gi  = i;
        req = 2'b00;
      end
      if (done != 2'b00) begin
        d    = done;
        span = i - gi;
        break;
      end
    end
    req = 2'b00;
  endtask

  typedef struct {
    logic [1:0] req;
    logic [7:0] l0;
    logic [7:0] l1;
    int         nwords;
    logic [1:0] exp_g;
  } vec_t;

  vec_t vecs [8];

  logic [1:0] g;
  logic [1:0] d;
  int span;
  int v0;
  int d0;
  int e0;
  bit seen;
  logic [1:0] alt_exp [16];

  initial begin
    // Pointer starts at 0 and flips to the other side of each owner.
    vecs[0] = '{2'b01, 8'd4, 8'd0, 4, 2'b01};
    vecs[1] = '{2'b10, 8'd0, 8'd3, 3, 2'b10};
    vecs[2] = '{2'b11, 8'd2, 8'd5, 2, 2'b01};
    vecs[3] = '{2'b11, 8'd2, 8'd5, 5, 2'b10};
    vecs[4] = '{2'b10, 8'd0, 8'd1, 1, 2'b10};
    vecs[5] = '{2'b11, 8'd0, 8'd3, 0, 2'b01};
    vecs[6] = '{2'b01, 8'd1, 8'd0, 1, 2'b01};
    vecs[7] = '{2'b10, 8'd0, 8'd7, 7, 2'b10};
    alt_exp = '{2'b01, 2'b01, 2'b01, 2'b00,
                2'b10, 2'b10, 2'b10, 2'b00,
                2'b01, 2'b01, 2'b01, 2'b00,
                2'b10, 2'b10, 2'b10, 2'b00};

    rst_n = 1'b0;
    flush = 1'b0;
    req   = '0;
    len0  = '0;
    len1  = '0;
    stall = '0;
    #1;
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_outs",
          64'({dvalid, done, error, busy, rdreq}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single bursts from the table.
    foreach (vecs[k]) begin
      v0 = vcount;
      push_fifo(vecs[k].nwords, vecs[k].exp_g[1],
                vecs[k].nwords);
      run_burst(vecs[k].req, vecs[k].l0, vecs[k].l1,
                g, d, span);
      check($sformatf("v%0d_grant", k), 64'(g),
            64'(vecs[k].exp_g));
      check($sformatf("v%0d_done", k), 64'(d),
            64'(vecs[k].exp_g));
      check($sformatf("v%0d_span", k), 64'(span),
            64'(vecs[k].nwords));
      @(negedge clk);
      check($sformatf("v%0d_idle", k),
            64'({grant, busy}), 64'd0);
      check($sformatf("v%0d_words", k),
            64'(vcount - v0), 64'(vecs[k].nwords));
    end

    // Both requesting, len 2 each: alternate with one idle cycle.
    push_fifo(2, 1'b0, 2);
    push_fifo(2, 1'b1, 2);
    push_fifo(2, 1'b0, 2);
    push_fifo(2, 1'b1, 2);
    req  = 2'b11;
    len0 = 8'd2;
    len1 = 8'd2;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("alt_grant_%0d", i), 64'(grant),
            64'(alt_exp[i]));
      if (i == 12) req = 2'b00;
    end

    // Stall toggling and a mid-burst empty FIFO.
    v0 = vcount;
    e0 = errcnt;
    push_fifo(2, 1'b1, 2);
    req   = 2'b10;
    len1  = 8'd3;
    stall = 2'b10;
    @(negedge clk);
    check("st_grant", 64'(grant), 64'b10);
    req = 2'b00;
    @(negedge clk);
    stall = 2'b00;
    @(negedge clk);
    stall = 2'b10;
    @(negedge clk);
    stall = 2'b00;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    push_fifo(1, 1'b1, 1);
    d = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done != 2'b00) begin
        d = done;
        break;
      end
    end
    check("st_done", 64'(d), 64'b10);
    @(negedge clk);
    check("st_words", 64'(vcount - v0), 64'd3);
    check("st_no_error", 64'(errcnt - e0), 64'd0);

    // Starvation: len 5 with only 2 words available.
    v0 = vcount;
    d0 = donecnt;
    push_fifo(2, 1'b0, 2);
    req  = 2'b01;
    len0 = 8'd5;
    @(negedge clk);
    check("to_grant", 64'(grant), 64'b01);
    req  = 2'b00;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (error) begin
        seen = 1'b1;
        break;
      end
    end
    check("to_error_seen", 64'(seen), 64'd1);
    check("to_idle", 64'({grant, busy}), 64'd0);
    #2;
    // 20 whole cycles without a read, then the error cycle.
    check("to_delay", 64'(err_cyc - last_rd), 64'd21);
    check("to_words", 64'(vcount - v0), 64'd2);
    check("to_no_done", 64'(donecnt - d0), 64'd0);
    @(negedge clk);
    run_burst(2'b11, 8'd0, 8'd0, g, d, span);
    check("to_next_grant", 64'(g), 64'b10);
    check("to_next_done", 64'(d), 64'b10);
    @(negedge clk);

    // Flush on the second read of a 6-word burst.
    v0 = vcount;
    d0 = donecnt;
    push_fifo(10, 1'b0, 1);
    req  = 2'b01;
    len0 = 8'd6;
    @(negedge clk);
    check("fl_grant", 64'(grant), 64'b01);
    req = 2'b00;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fl_grant_drop", 64'(grant), 64'd0);
    check("fl_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 40 && !fifo_empty; i++)
      @(negedge clk);
    check("fl_drained", 64'(fifo_empty), 64'd1);
    check("fl_busy_at_empty", 64'(busy), 64'd1);
    @(negedge clk);
    check("fl_busy_fall", 64'(busy), 64'd0);
    check("fl_words", 64'(vcount - v0), 64'd1);
    check("fl_no_done", 64'(donecnt - d0), 64'd0);

    // Async reset mid-burst; pointer is first moved to 1.
    run_burst(2'b01, 8'd0, 8'd0, g, d, span);
    check("rs_pre_grant", 64'(g), 64'b01);
    @(negedge clk);
    push_fifo(4, 1'b1, 1);
    req  = 2'b10;
    len1 = 8'd4;
    @(negedge clk);
    check("rs_grant", 64'(grant), 64'b10);
    req = 2'b00;
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rs_grant_zero", 64'(grant), 64'd0);
    check("rs_outs_zero",
          64'({dvalid, done, error, busy, rdreq}), 64'd0);
    check("rs_data_zero", 64'(data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_burst(2'b11, 8'd0, 8'd0, g, d, span);
    check("rs_first_grant", 64'(g), 64'b01);
    @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_fifo_read_arbiter.md
Name: rx_fifo_read_arbiter

Overview:
Shares the read port of the PC receive FIFO (32-bit payload words, normal-mode FIFO with q valid one cycle after rdreq) between two downstream consumers. Example consumers are the frame loader and the config register writer. Each consumer requests a burst of N words. The block grants requesters round-robin, paces FIFO reads against empty and per-consumer stall, and delivers words with per-requester valid strobes. It also provides a flush path (driven from the PC reset command) and a starvation timeout.

Parameters:
LEN_W, 8, width of burst length inputs; max burst 2^LEN_W-1 words
TIMEOUT_CYCLES, 50000, cycles with no read issued during a burst before abort (1 ms at 50 MHz)

Ports:
i_clock  in  1  system clock, 50 MHz
i_reset_n  in  1  asynchronous active-low reset
i_flush  in  1  1-cycle pulse: abort any burst and drain FIFO until empty
i_fifo_empty  in  1  FIFO empty flag
i_fifo_q  in  32  FIFO output word, valid the cycle after rdreq
o_fifo_rdreq  out  1  FIFO read request (combinational from registered state and inputs)
i_req  in  2  per-requester burst request, level, held until grant
i_len0  in  LEN_W  burst length, requester 0
i_len1  in  LEN_W  burst length, requester 1
i_stall  in  2  per-requester back-pressure; suppresses new reads only
o_grant  out  2  one-hot current owner; 0 when idle
o_data  out  32  equals i_fifo_q (pass-through)
o_data_valid  out  2  per-requester word strobe
o_done  out  2  1-cycle pulse on burst completion
o_error  out  1  1-cycle pulse on timeout abort
o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; round-robin pointer = requester 0; counters cleared.
- States: IDLE, BURST, LAST, FLUSH.
- IDLE:
  - If i_flush: go to FLUSH (priority over requests).
  - Else if any i_req: grant the pointed requester if it requests, otherwise the other. Latch its length into remaining, set o_grant next cycle, go to BURST.
  - Both requesting: pointer decides.
- Zero length: the grant is issued for one cycle with no reads; o_done pulses in that BURST cycle; return to IDLE; pointer flips.
- BURST:
  - o_fifo_rdreq = !i_fifo_empty & !i_stall[g] & (remaining != 0).
  - Each rdreq decrements remaining.
  - o_data_valid[g] = rdreq delayed one cycle (registered). o_data carries i_fifo_q in that cycle.
  - When the rdreq that takes remaining to 0 issues, go to LAST.
- LAST (1 cycle):
  - Final o_data_valid[g] and o_done[g] assert together.
  - Next state IDLE; o_grant clears; pointer flips to the other requester.
  - Arbitration resumes in the following IDLE cycle: at least 1 idle cycle between bursts.
- Stall: affects rdreq only. A word already in flight is still delivered the next cycle regardless of stall.
- Timeout:
  - A 16-bit idle counter runs in BURST while no rdreq issues (stall or empty); it is cleared on each rdreq.
  - On reaching TIMEOUT_CYCLES: o_error pulses, burst aborts with no o_done, state goes to IDLE, pointer flips.
  - A pending in-flight valid is still delivered in the abort cycle.
- FLUSH:
  - Entered from any state on i_flush. Current burst aborts with no o_done; o_grant clears immediately next cycle.
  - Suppress all o_data_valid, including any in-flight word.
  - o_fifo_rdreq = !i_fifo_empty. Exit to IDLE on the first cycle i_fifo_empty is sampled high.
  - i_flush while already in FLUSH: stay in FLUSH.
- Simultaneous events:
  - i_flush beats the timeout.
  - An i_req drop mid-burst is ignored; the burst runs to completion or abort.
- Invariants:
  - Never assert rdreq when i_fifo_empty = 1.
  - o_grant is always one-hot or zero.
  - The o_data_valid bit set is always a subset of o_grant, or o_grant from the previous cycle.
- Async reset mid-burst: immediate return to reset values; a word in flight is discarded.

Test Plan:
- FIFO preloaded with 0x00000001..0x00000004; i_req=01, i_len0=4 -> 4 consecutive rdreq; o_data_valid[0] on 4 consecutive cycles with data 1..4; o_done[0] with the 4th valid; o_grant back to 0.
- i_req=11 held, i_len0=i_len1=2, FIFO holds 8 words -> grants alternate 0,1,0,1; each burst gets 2 words in order; exactly 1 idle cycle between bursts.
- Requester 1 burst len 3, i_stall[1] toggled 1010 during the burst, FIFO emptied after word 2 then refilled -> no rdreq while stalled or empty; exactly 3 valids; data order preserved; no o_error.
- Len 5 burst, FIFO holds only 2 words, TIMEOUT_CYCLES=20 -> 2 valids, then o_error pulses 20 cycles after the last rdreq; no o_done; block is IDLE and grants the other requester next.
- i_flush mid-burst (word 2 of 6) with 10 words in FIFO -> o_grant drops; no further o_data_valid; rdreq continues until empty; o_busy falls the cycle after empty is seen; no o_done.
- i_reset_n pulled low asynchronously mid-burst -> all outputs 0 without a clock edge; after release the first grant goes to requester 0.
